// File: rtl/fragment_shader.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fragment_shader
// Per-pixel colour interpolation stage behind the triangle rasterizer.
// Each visible fragment is shaded as colour = (uw*ca + vw*cb + ww*cc) / aw
// per R,G,B channel using a CW-iteration restoring divider (three channels
// in parallel). One fragment is in flight at a time.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fragment handshake (ready only in IDLE)
//   in_x, in_y          pixel coordinates
//   uw, vw, ww, aw      barycentric weights and their sum (divisor)
//   visible             fragment inside triangle; invisible ones are dropped
//   ca, cb, cc          vertex colours {R,G,B}, sampled at the handshake
//   out_valid/out_ready shaded pixel handshake to the framebuffer writer
//   out_x, out_y        pixel coordinates of the shaded pixel
//   out_color           shaded colour {R,G,B}
//   busy                high whenever a fragment is being processed
//
// Build option
//   FRAG_SHADER_ROUND_EN  adds aw>>1 to each numerator so the result rounds
//                         to nearest instead of truncating.
// ----------------------------------------------------------------------------
module fragment_shader #(
   parameter int unsigned XW = 10,
   parameter int unsigned WW = 20,
   parameter int unsigned CW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XW-1:0]   in_x,
   input  logic [XW-1:0]   in_y,
   input  logic [WW-1:0]   uw,
   input  logic [WW-1:0]   vw,
   input  logic [WW-1:0]   ww,
   input  logic [WW-1:0]   aw,
   input  logic            visible,
   input  logic [3*CW-1:0] ca,
   input  logic [3*CW-1:0] cb,
   input  logic [3*CW-1:0] cc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XW-1:0]   out_x,
   output logic [XW-1:0]   out_y,
   output logic [3*CW-1:0] out_color,
   output logic            busy
);

`ifdef FRAG_SHADER_ROUND_EN
   localparam int unsigned NW = WW + CW + 3;
`else
   localparam int unsigned NW = WW + CW + 2;
`endif
   localparam int unsigned IW = (CW > 1) ? $clog2(CW) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DIV, S_OUT} state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d, y_q, y_d;
   logic [WW-1:0]   uw_q, uw_d, vw_q, vw_d, ww_q, ww_d, aw_q, aw_d;
   logic [3*CW-1:0] ca_q, ca_d, cb_q, cb_d, cc_q, cc_d;
   logic [NW-1:0]   num_q [3];
   logic [NW-1:0]   num_d [3];
   logic [CW-1:0]   quo_q [3];
   logic [CW-1:0]   quo_d [3];
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [NW-1:0]   div_sh;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      uw_d    = uw_q;
      vw_d    = vw_q;
      ww_d    = ww_q;
      aw_d    = aw_q;
      ca_d    = ca_q;
      cb_d    = cb_q;
      cc_d    = cc_q;
      num_d   = num_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      div_sh  = NW'(aw_q) << cnt_q;

      case (state_q)
         S_IDLE: begin
            // Invisible fragments are consumed (in_ready=1) and simply dropped.
            if (in_valid && visible) begin
               x_d     = in_x;
               y_d     = in_y;
               uw_d    = uw;
               vw_d    = vw;
               ww_d    = ww;
               aw_d    = aw;
               ca_d    = ca;
               cb_d    = cb;
               cc_d    = cc;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            for (int unsigned c = 0; c < 3; c++) begin
               num_d[c] = NW'(uw_q) * NW'(ca_q[c*CW +: CW])
                        + NW'(vw_q) * NW'(cb_q[c*CW +: CW])
                        + NW'(ww_q) * NW'(cc_q[c*CW +: CW]);
`ifdef FRAG_SHADER_ROUND_EN
               num_d[c] = num_d[c] + NW'(aw_q >> 1);
`endif
               quo_d[c] = '0;
            end
            cnt_d   = IW'(CW - 1);
            state_d = S_DIV;
         end
         S_DIV: begin
            // aw==0 leaves every quotient bit clear. A quotient that would not
            // fit in CW bits keeps passing every compare, so it saturates to
            // all ones without extra logic.
            for (int unsigned c = 0; c < 3; c++) begin
               if ((aw_q != '0) && (num_q[c] >= div_sh)) begin
                  num_d[c]        = num_q[c] - div_sh;
                  quo_d[c][cnt_q] = 1'b1;
               end
            end
            if (cnt_q == '0) state_d = S_OUT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         uw_q    <= '0;
         vw_q    <= '0;
         ww_q    <= '0;
         aw_q    <= '0;
         ca_q    <= '0;
         cb_q    <= '0;
         cc_q    <= '0;
         num_q   <= '{default: '0};
         quo_q   <= '{default: '0};
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         uw_q    <= uw_d;
         vw_q    <= vw_d;
         ww_q    <= ww_d;
         aw_q    <= aw_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         cc_q    <= cc_d;
         num_q   <= num_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_color = {quo_q[2], quo_q[1], quo_q[0]};

endmodule

// File: tb/tb_fragment_shader.sv
`timescale 1ns/1ps
// Directed + randomized bench for fragment_shader with a plain-arithmetic
// reference model of the shading rule.
module tb_fragment_shader;

   localparam int XW = 10;
   localparam int WW = 20;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XW-1:0]   in_x = '0;
   logic [XW-1:0]   in_y = '0;
   logic [WW-1:0]   uw = '0, vw = '0, ww = '0, aw = '0;
   logic            visible = 1'b0;
   logic [3*CW-1:0] ca = '0, cb = '0, cc = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XW-1:0]   out_x;
   logic [XW-1:0]   out_y;
   logic [3*CW-1:0] out_color;
   logic            busy;

   int total = 0;
   int bad   = 0;

   fragment_shader #(.XW(XW), .WW(WW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y),
      .uw(uw), .vw(vw), .ww(ww), .aw(aw), .visible(visible),
      .ca(ca), .cb(cb), .cc(cc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_color(out_color),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: per channel floor((sum of weight*colour [+ aw/2]) / aw),
   // clamped to 255; zero when aw is zero.
   function automatic logic [23:0] model(input longint unsigned u, v, w, a,
                                         input logic [23:0] pa, pb, pc);
      logic [23:0] res;
      longint unsigned n, q;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         n = u * longint'(pa[ch*8 +: 8]) + v * longint'(pb[ch*8 +: 8])
           + w * longint'(pc[ch*8 +: 8]);
`ifdef FRAG_SHADER_ROUND_EN
         n = n + a / 2;
`endif
         if (a == 0) q = 0;
         else        q = n / a;
         if (q > 255) q = 255;
         res[ch*8 +: 8] = q[7:0];
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one fragment and completes the handshake, then scrambles every
   // input so that only the values captured at the handshake can matter.
   task automatic send(input logic [XW-1:0] x, y, input logic [WW-1:0] u, v, w, a,
                       input logic vis, input logic [23:0] pa, pb, pc);
      int n;
      @(negedge clk);
      in_x = x; in_y = y; uw = u; vw = v; ww = w; aw = a;
      visible = vis; ca = pa; cb = pb; cc = pc; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; visible = 1'b0;
      in_x = XW'($urandom); in_y = XW'($urandom);
      uw = WW'($urandom); vw = WW'($urandom); ww = WW'($urandom); aw = WW'($urandom);
      ca = 24'($urandom); cb = 24'($urandom); cc = 24'($urandom);
   endtask

   // Counts rising edges after the handshake edge until the edge at which
   // out_valid is first seen high by the consumer.
   task automatic wait_out(output int lat);
      logic v;
      lat = 0;
      v = 1'b0;
      while (!v && lat < 40) begin
         @(negedge clk);
         v = out_valid;
         @(posedge clk);
         lat++;
      end
      #1;
      if (!v) check("out_valid_timeout", 0, 1);
   endtask

   task automatic finish_px(input string tag, input logic [XW-1:0] x, y,
                            input logic [23:0] col, input int hold);
      int lat;
      wait_out(lat);
      check({tag, "_latency"}, 64'(lat), 64'(CW + 2));
      check({tag, "_x"}, 64'(out_x), 64'(x));
      check({tag, "_y"}, 64'(out_y), 64'(y));
      check({tag, "_color"}, 64'(out_color), 64'(col));
      check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_data"}, {out_x, out_y, out_color}, {x, y, col});
         check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_accept_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_accept_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_accept_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [23:0] exp_col;
      logic [WW-1:0] ru, rv, rw, ra;
      logic [23:0] rca, rcb, rcc;
      logic [XW-1:0] rx, ry;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_data", {out_x, out_y, out_color}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic interpolation: equal weights over pure R/G/B vertices
      send(10'd5, 10'd7, 20'd100, 20'd100, 20'd100, 20'd300, 1'b1,
           24'hFF0000, 24'h00FF00, 24'h0000FF);
      finish_px("basic", 10'd5, 10'd7, 24'h555555, 0);

      // Rounding midpoint
`ifdef FRAG_SHADER_ROUND_EN
      exp_col = 24'h808080;
`else
      exp_col = 24'h7F7F7F;
`endif
      send(10'd1, 10'd2, 20'd1, 20'd1, 20'd0, 20'd2, 1'b1,
           24'hFFFFFF, 24'h000000, 24'h000000);
      finish_px("round", 10'd1, 10'd2, exp_col, 0);

      // Invisible fragments are consumed with no effect
      @(negedge clk);
      in_valid = 1'b1; visible = 1'b0; in_x = 10'd9; aw = 20'd3; uw = 20'd3;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("invis_in_ready", 64'(in_ready), 64'd1);
         check("invis_out_valid", 64'(out_valid), 64'd0);
         check("invis_busy", 64'(busy), 64'd0);
      end
      in_valid = 1'b0;

      // Degenerate divisor
      send(10'd3, 10'd4, 20'd50, 20'd60, 20'd70, 20'd0, 1'b1,
           24'h123456, 24'hABCDEF, 24'hFFFFFF);
      finish_px("aw_zero", 10'd3, 10'd4, 24'h000000, 0);

      // Saturation: divisor far smaller than the weight sum
      send(10'd11, 10'd12, 20'd1000, 20'd0, 20'd0, 20'd1, 1'b1,
           24'hFF8001, 24'h000000, 24'h000000);
      finish_px("saturate", 10'd11, 10'd12, 24'hFFFFFF, 0);

      // Backpressure: five held cycles in OUT
      send(10'd1023, 10'd512, 20'd7, 20'd3, 20'd0, 20'd10, 1'b1,
           24'h10C8FF, 24'hF00A00, 24'h000000);
      finish_px("backpr", 10'd1023, 10'd512,
                model(7, 3, 0, 10, 24'h10C8FF, 24'hF00A00, 24'h000000), 5);

      // Reset during the third DIV cycle, then a fresh fragment
      send(10'd20, 10'd21, 20'd5, 20'd5, 20'd5, 20'd15, 1'b1,
           24'h808080, 24'h808080, 24'h808080);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      repeat (CW + 4) begin
         @(negedge clk);
         check("midrst_no_output", 64'(out_valid), 64'd0);
      end
      send(10'd30, 10'd31, 20'd2, 20'd1, 20'd1, 20'd4, 1'b1,
           24'h0040FF, 24'h804000, 24'hFF0080);
      finish_px("after_rst", 10'd30, 10'd31,
                model(2, 1, 1, 4, 24'h0040FF, 24'h804000, 24'hFF0080), 0);

      // Randomized fragments against the reference model
      for (int t = 0; t < 24; t++) begin
         rx  = XW'($urandom);
         ry  = XW'($urandom);
         ru  = WW'($urandom_range(0, 262143));
         rv  = WW'($urandom_range(0, 262143));
         rw  = WW'($urandom_range(0, 262143));
         ra  = (t % 4 == 3) ? WW'($urandom) : ru + rv + rw;
         rca = 24'($urandom);
         rcb = 24'($urandom);
         rcc = 24'($urandom);
         send(rx, ry, ru, rv, rw, ra, 1'b1, rca, rcb, rcc);
         finish_px("rand", rx, ry, model(ru, rv, rw, ra, rca, rcb, rcc),
                   int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
